wide_adder_seq: RTL and testbench

- Multi-cycle sequencer that computes a COUNT*WORDS-bit addition by time-sharing one COUNT-bit select_adder instance, one slice per cycle, LSB slice first.
- Carry is registered between slices.
- Used wherever wide sums are needed but only one narrow carry-select adder is affordable.
- valid/ready handshake on both the operand side and the result side.

---
 rtl/wide_adder_seq.sv | 131 +++++++++++++
 tb/tb_wide_adder_seq.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/wide_adder_seq.sv
// Multi-cycle wide adder: one COUNT-bit carry-select adder is time-shared over
// WORDS slices, LSB slice first, with the inter-slice carry held in a register.

module select_adder #(
    parameter int COUNT = 4
) (
    input  logic [COUNT-1:0] A,
    input  logic [COUNT-1:0] B,
    input  logic             Cin,
    output logic [COUNT-1:0] S,
    output logic             Cout
);
    logic [COUNT:0] sum0;
    logic [COUNT:0] sum1;

    // Both carry-in cases are computed up front; Cin only picks one.
    assign sum0 = {1'b0, A} + {1'b0, B};
    assign sum1 = {1'b0, A} + {1'b0, B} + {{COUNT{1'b0}}, 1'b1};
    assign {Cout, S} = Cin ? sum1 : sum0;
endmodule

module wide_adder_seq #(
    parameter int COUNT = 4,
    parameter int WORDS = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [COUNT*WORDS-1:0] A,
    input  logic [COUNT*WORDS-1:0] B,
    input  logic                   Cin,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [COUNT*WORDS-1:0] S,
    output logic                   Cout,
    output logic                   busy
);
    localparam int W  = COUNT * WORDS;
    localparam int IW = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [IW-1:0] LAST = IW'(WORDS - 1);

    // Handshake: a transfer happens on a rising edge where valid and ready are
    // both high; operands are taken only then, results are held until consumed.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state;
    state_t next_state;

    logic [W-1:0]     op_a;
    logic [W-1:0]     op_b;
    logic             carry;
    logic [IW-1:0]    idx;
    logic [W-1:0]     s_reg;
    logic             cout_reg;
    logic [31:0]      base;
    logic [COUNT-1:0] slice_s;
    logic             slice_cout;

    assign base = 32'(idx) * 32'(COUNT);

    select_adder #(.COUNT(COUNT)) u_slice (
        .A    (op_a[base +: COUNT]),
        .B    (op_b[base +: COUNT]),
        .Cin  (carry),
        .S    (slice_s),
        .Cout (slice_cout)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        busy       = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) next_state = RUN;
            end
            RUN: begin
                busy = 1'b1;
                if (idx == LAST) next_state = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_a     <= '0;
            op_b     <= '0;
            carry    <= 1'b0;
            idx      <= '0;
            s_reg    <= '0;
            cout_reg <= 1'b0;
        end else if (state == IDLE && in_valid) begin
            op_a  <= A;
            op_b  <= B;
            carry <= Cin;
            idx   <= '0;
            s_reg <= '0;
        end else if (state == RUN) begin
            s_reg[base +: COUNT] <= slice_s;
            carry                <= slice_cout;
            if (idx == LAST) begin
                cout_reg <= slice_cout;
            end else begin
                idx <= idx + IW'(1);
            end
        end
    end

    assign S    = s_reg;
    assign Cout = cout_reg;
endmodule

// File: tb/tb_wide_adder_seq.sv
// Bench for wide_adder_seq: a 4x4 instance for the main scenarios and a
// 4x1 instance for the single-slice case.

module tb_wide_adder_seq;
    localparam int W  = 16;
    localparam int W1 = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid, in_ready, out_valid, out_ready, busy;
    logic [W-1:0]  a, b, s;
    logic          cin, cout;

    logic          w1_in_valid, w1_in_ready, w1_out_valid, w1_out_ready, w1_busy;
    logic [W1-1:0] w1_a, w1_b, w1_s;
    logic          w1_cin, w1_cout;

    logic [W:0]    exp_q[$];
    logic [W1:0]   exp1_q[$];
    int            n_checks = 0;
    int            n_fail   = 0;

    always #5 clk = ~clk;

    wide_adder_seq #(.COUNT(4), .WORDS(4)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .A(a), .B(b), .Cin(cin), .out_valid(out_valid), .out_ready(out_ready),
        .S(s), .Cout(cout), .busy(busy)
    );

    wide_adder_seq #(.COUNT(4), .WORDS(1)) dut1 (
        .clk(clk), .rst(rst), .in_valid(w1_in_valid), .in_ready(w1_in_ready),
        .A(w1_a), .B(w1_b), .Cin(w1_cin), .out_valid(w1_out_valid),
        .out_ready(w1_out_ready), .S(w1_s), .Cout(w1_cout), .busy(w1_busy)
    );

    // Offer one operand set; returns at the falling edge after the accept edge.
    task automatic send_op(input logic [W-1:0] op_a, input logic [W-1:0] op_b,
                           input logic op_cin, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 30 && !ok; i++) begin
            @(negedge clk);
            if (in_ready === 1'b1) ok = 1'b1;
        end
        if (ok) begin
            in_valid = 1'b1;
            a = op_a; b = op_b; cin = op_cin;
            exp_q.push_back({1'b0, op_a} + {1'b0, op_b} + {{W{1'b0}}, op_cin});
            @(negedge clk);
            in_valid = 1'b0;
            a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
        end
    endtask

    task automatic wait_out(output bit ok);
        ok = (out_valid === 1'b1);
        for (int i = 0; i < 30 && !ok; i++) begin
            @(negedge clk);
            if (out_valid === 1'b1) ok = 1'b1;
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        #1;
        n_checks++;
        if ({s, cout, out_valid, busy, in_ready} !== {16'h0000, 1'b0, 1'b0, 1'b0, 1'b1}) begin
            n_fail++;
            $display("FAIL reset_state got S=%h Cout=%b ov=%b busy=%b ir=%b want 0000 0 0 0 1",
                     s, cout, out_valid, busy, in_ready);
        end
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_latency;
        bit ok;
        logic [W:0] e;
        send_op(16'h0000, 16'h0000, 1'b0, ok);
        n_checks++;
        if (!ok || in_ready !== 1'b0 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL lat_accept ok=%b ir=%b busy=%b want 1 0 1", ok, in_ready, busy);
        end
        for (int j = 1; j <= 4; j++) begin
            @(negedge clk);
            n_checks++;
            if (out_valid !== (j == 4)) begin
                n_fail++;
                $display("FAIL lat_out_valid edge=%0d got=%b want=%b", j, out_valid, (j == 4));
            end
        end
        e = exp_q.pop_front();
        n_checks++;
        if ({cout, s} !== e) begin
            n_fail++;
            $display("FAIL lat_result got=%h want=%h", {cout, s}, e);
        end
        @(negedge clk);
        n_checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL lat_release ov=%b ir=%b want 0 1", out_valid, in_ready);
        end
    endtask

    task automatic test_sum(input string name, input logic [W-1:0] op_a,
                            input logic [W-1:0] op_b, input logic op_cin);
        bit ok;
        logic [W:0] e;
        send_op(op_a, op_b, op_cin, ok);
        if (ok) wait_out(ok);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s timeout got=none want=result", name);
            exp_q.delete();
        end else begin
            e = exp_q.pop_front();
            if ({cout, s} !== e) begin
                n_fail++;
                $display("FAIL %s got=%h want=%h", name, {cout, s}, e);
            end
        end
        @(negedge clk);
    endtask

    task automatic test_backpressure;
        bit ok;
        logic [W:0] e;
        out_ready = 1'b0;
        send_op(16'h1234, 16'h4321, 1'b0, ok);
        if (ok) wait_out(ok);
        e = exp_q.pop_front();
        n_checks++;
        if (!ok || {cout, s} !== e) begin
            n_fail++;
            $display("FAIL bp_first ok=%b got=%h want=%h", ok, {cout, s}, e);
        end
        in_valid = 1'b1; a = 16'hAAAA; b = 16'h5555; cin = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            n_checks++;
            if (s !== 16'h5555 || cout !== 1'b0 || in_ready !== 1'b0 || out_valid !== 1'b1) begin
                n_fail++;
                $display("FAIL bp_hold cyc=%0d S=%h Cout=%b ir=%b ov=%b want 5555 0 0 1",
                         i, s, cout, in_ready, out_valid);
            end
        end
        out_ready = 1'b1;
        @(negedge clk);
        n_checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || s !== 16'h5555) begin
            n_fail++;
            $display("FAIL bp_idle ov=%b ir=%b S=%h want 0 1 5555", out_valid, in_ready, s);
        end
        exp_q.push_back(17'h0FFFF);
        @(negedge clk);
        in_valid = 1'b0;
        n_checks++;
        if (busy !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_second_accept busy=%b want 1", busy);
        end
        wait_out(ok);
        e = exp_q.pop_front();
        n_checks++;
        if (!ok || {cout, s} !== e) begin
            n_fail++;
            $display("FAIL bp_second ok=%b got=%h want=%h", ok, {cout, s}, e);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid_run;
        bit ok;
        send_op(16'hFFFF, 16'hFFFF, 1'b1, ok);
        @(negedge clk);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        void'(exp_q.pop_back());
        n_checks++;
        if (!ok || s !== 16'h0000 || cout !== 1'b0 || out_valid !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_mid ok=%b S=%h Cout=%b ov=%b busy=%b want 0000 0 0 0",
                     ok, s, cout, out_valid, busy);
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_mid_ready got=%b want=1", in_ready);
        end
        test_sum("rst_mid_fresh", 16'h0001, 16'h0002, 1'b0);
    endtask

    task automatic test_back_to_back;
        for (int i = 0; i < 8; i++) begin
            test_sum("b2b_random", 16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)));
        end
    endtask

    task automatic test_one_word;
        logic [W1:0] e;
        @(negedge clk);
        n_checks++;
        if (w1_in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL w1_ready got=%b want=1", w1_in_ready);
        end
        w1_in_valid = 1'b1; w1_a = 4'hF; w1_b = 4'h1; w1_cin = 1'b1;
        exp1_q.push_back({1'b0, w1_a} + {1'b0, w1_b} + 5'd1);
        @(negedge clk);
        w1_in_valid = 1'b0; w1_a = 4'h0; w1_b = 4'h0; w1_cin = 1'b0;
        n_checks++;
        if (w1_busy !== 1'b1 || w1_out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL w1_run busy=%b ov=%b want 1 0", w1_busy, w1_out_valid);
        end
        @(negedge clk);
        e = exp1_q.pop_front();
        n_checks++;
        if (w1_out_valid !== 1'b1 || {w1_cout, w1_s} !== e) begin
            n_fail++;
            $display("FAIL w1_result ov=%b got=%h want=%h", w1_out_valid, {w1_cout, w1_s}, e);
        end
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1;
        in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; out_ready = 1'b1;
        w1_in_valid = 1'b0; w1_a = '0; w1_b = '0; w1_cin = 1'b0; w1_out_ready = 1'b1;
        test_reset();
        test_latency();
        test_sum("carry_0_to_2", 16'h00FF, 16'h0001, 1'b0);
        test_sum("wrap_cin", 16'hFFFF, 16'h0001, 1'b1);
        test_backpressure();
        test_reset_mid_run();
        test_back_to_back();
        test_one_word();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
